avmm_arb2_rw16: RTL and testbench
=================================

// Module: avmm_arb2_rw16
// PURPOSE
//  Two-port round-robin arbiter/sequencer sharing one 16-bit Avalon-MM register slave with waitrequest.
//  Two upstream Avalon-MM slave ports (s0, s1) share one downstream master port (m0), one transfer at a time.
//  A per-transfer timeout watchdog aborts hung downstream accesses and counts them.
//  Sits between host bridges/test masters and test/config register slaves in the Qsys system.
// PARAMETERS
//  TIMEOUT      64      max cycles m0 command stays asserted before abort (>=2)
//  RD_SETTLE    1       cycles after m0 read completion before m0 readdata is captured (0..3); covers registered-readdata slaves
//  ERR_RDATA    16'hDEAD readdata returned upstream on aborted read
// PORTS
//  csi_MCLK_clk          in   1   system clock; all logic on rising edge
//  rsi_MRST_reset_n      in   1   reset, asynchronous, active-low
//  avs_s0_writedata      in   16  port 0 write data
//  avs_s0_readdata       out  16  port 0 read data, valid when avs_s0_waitrequest=0 with avs_s0_read=1
//  avs_s0_address        in   6   port 0 word address
//  avs_s0_byteenable     in   2   port 0 byte lanes [1]=15:8 [0]=7:0
//  avs_s0_write          in   1   port 0 write request
//  avs_s0_read           in   1   port 0 read request
//  avs_s0_waitrequest    out  1   port 0 stall
//  avs_s1_*              --   --  identical set for port 1
//  avm_m0_writedata      out  16  downstream write data
//  avm_m0_readdata       in   16  downstream read data
//  avm_m0_address        out  6   downstream address
//  avm_m0_byteenable     out  2   downstream byte lanes
//  avm_m0_write          out  1   downstream write command
//  avm_m0_read           out  1   downstream read command
//  avm_m0_waitrequest    in   1   downstream stall
//  coe_err_sticky        out  1   set on any abort; cleared only by reset
//  coe_err_cnt           out  8   abort count, saturates at 255
// BEHAVIOUR
//  Reset: state IDLE; all avm_m0_* outputs 0; both avs_*_waitrequest 1; readdata 0; last_grant=1 (s0 wins first tie); err 0.
//  Reset mid-transfer: avm_m0_read/write drop immediately (async); in-flight transfer discarded, no upstream response.
//  IDLE: req_n = read_n|write_n. If read&write both set on one port, read wins. One requester -> grant it; both -> grant
//   !last_grant. Register address/writedata/byteenable/cmd into m0 regs, clear timer, -> ISSUE.
//  ISSUE: avm_m0_read or avm_m0_write =1, other m0 outputs stable. Each cycle:
//   avm_m0_waitrequest=0 -> command done; write -> RESP; read -> SETTLE (or RESP capturing readdata now if RD_SETTLE=0).
//   else timer++; timer==TIMEOUT-1 -> abort: err_sticky=1, err_cnt++ (sat), rdata_q=ERR_RDATA, -> RESP.
//  SETTLE: m0 command 0; wait RD_SETTLE cycles, capture avm_m0_readdata into rdata_q on last, -> RESP.
//  RESP: granted port waitrequest=0 exactly one cycle, readdata=rdata_q; last_grant<=granted; -> IDLE.
//  Upstream waitrequest is 1 in every other cycle (incl. idle); ungranted port is held until its turn.
//  Latency (no downstream stall, write): request at cycle 0 -> upstream waitrequest low at cycle 2; read adds RD_SETTLE.
//  Requester dropping its command before RESP (protocol violation): downstream access still completes; response discarded.
//  Back-to-back: a port still requesting in the IDLE after its RESP is a new transfer; alternation preserved under contention.
//  m0 command never asserted in IDLE/SETTLE/RESP; at most one downstream command per grant.
// STRUCTURE
//  Shared package (avmm_pkg): state encoding IDLE/ISSUE/SETTLE/RESP, AVMM_DW=16, AVMM_AW=6, ERR_RDATA default.
//  One sub-module: rr_arb2 (2-way round-robin grant: req[1:0], last_grant, gnt[1:0]; combinational, one-hot gnt).
//  Top holds FSM, command/readdata registers, timeout counter, error counter.
// TESTING (bench: this block + 16-bit test register slave, plus a stuck-waitrequest stub)
//  s0 write addr 0 data 16'h1234 be 2'b11 -> one m0 write, s0 waitrequest low cycle 2; then s1 read addr 3 -> 16'h1237.
//  s0 write addr 1 data 16'h00FF be 2'b01 -> slave data low byte 8'h00, high byte unchanged; s0 read addr 0 -> 16'h1200.
//  s0 and s1 read same cycle, both held 4 transfers -> grants s0,s1,s0,s1; never two m0 commands overlapping.
//  Stub holds avm_m0_waitrequest=1, TIMEOUT=64, s1 read -> s1 readdata 16'hDEAD at cycle ~66, err_sticky=1, err_cnt=1.
//  256 aborts -> err_cnt saturates at 255; next normal read still returns correct data.
//  Assert reset_n low in ISSUE -> avm_m0_read/write 0 same cycle, both waitrequest 1; after release s0 wins first tie.

Source files
------------

// File: rtl/avmm_pkg.sv
// Shared types and widths for the 16-bit Avalon-MM arbiter slice.
package avmm_pkg;

    localparam int unsigned AVMM_DW = 16;
    localparam int unsigned AVMM_AW = 6;
    localparam int unsigned AVMM_BW = AVMM_DW / 8;

    localparam logic [AVMM_DW-1:0] ERR_RDATA_DEF = 16'hDEAD;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [AVMM_AW-1:0] addr;
        logic [AVMM_DW-1:0] wdata;
        logic [AVMM_BW-1:0] be;
        logic               rd;
        logic               wr;
    } avmm_cmd_t;

endpackage

// File: rtl/avmm_arb2_rw16_rr_arb2.sv
// Two-way round-robin grant; the port that did not win last time wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt_c
);

    always_comb begin
        gnt_c = 2'b00;
        case (req)
            2'b01:   gnt_c = 2'b01;
            2'b10:   gnt_c = 2'b10;
            2'b11:   gnt_c = last_grant ? 2'b01 : 2'b10;
            default: gnt_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/avmm_arb2_rw16.sv
// Two-port round-robin sequencer onto one 16-bit Avalon-MM slave, with a
// per-transfer timeout watchdog and a saturating abort counter.
module avmm_arb2_rw16
    import avmm_pkg::*;
#(
    parameter int unsigned         TIMEOUT   = 64,
    parameter int unsigned         RD_SETTLE = 1,
    parameter logic [AVMM_DW-1:0]  ERR_RDATA = ERR_RDATA_DEF
) (
    input  logic               csi_MCLK_clk,
    input  logic               rsi_MRST_reset_n,

    input  logic [AVMM_DW-1:0] avs_s0_writedata,
    output logic [AVMM_DW-1:0] avs_s0_readdata,
    input  logic [AVMM_AW-1:0] avs_s0_address,
    input  logic [AVMM_BW-1:0] avs_s0_byteenable,
    input  logic               avs_s0_write,
    input  logic               avs_s0_read,
    output logic               avs_s0_waitrequest,

    input  logic [AVMM_DW-1:0] avs_s1_writedata,
    output logic [AVMM_DW-1:0] avs_s1_readdata,
    input  logic [AVMM_AW-1:0] avs_s1_address,
    input  logic [AVMM_BW-1:0] avs_s1_byteenable,
    input  logic               avs_s1_write,
    input  logic               avs_s1_read,
    output logic               avs_s1_waitrequest,

    output logic [AVMM_DW-1:0] avm_m0_writedata,
    input  logic [AVMM_DW-1:0] avm_m0_readdata,
    output logic [AVMM_AW-1:0] avm_m0_address,
    output logic [AVMM_BW-1:0] avm_m0_byteenable,
    output logic               avm_m0_write,
    output logic               avm_m0_read,
    input  logic               avm_m0_waitrequest,

    output logic               coe_err_sticky,
    output logic [7:0]         coe_err_cnt
);

    localparam int unsigned TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST  = TW'(TIMEOUT - 1);
    localparam logic [1:0]    SETTLE_LAST = 2'((RD_SETTLE == 0) ? 0 : RD_SETTLE - 1);

    state_t              state;
    logic [TW-1:0]       timer;
    logic [1:0]          settle_cnt;
    logic                gnt_port;
    logic                last_grant;
    logic [AVMM_DW-1:0]  rdata_q;

    logic [1:0]          req_c;
    logic [1:0]          gnt_c;
    avmm_cmd_t           cmd0_c;
    avmm_cmd_t           cmd1_c;
    avmm_cmd_t           sel_c;

    // Read wins when a port presents read and write together.
    assign cmd0_c = '{addr: avs_s0_address, wdata: avs_s0_writedata, be: avs_s0_byteenable,
                      rd: avs_s0_read, wr: avs_s0_write & ~avs_s0_read};
    assign cmd1_c = '{addr: avs_s1_address, wdata: avs_s1_writedata, be: avs_s1_byteenable,
                      rd: avs_s1_read, wr: avs_s1_write & ~avs_s1_read};
    assign sel_c  = gnt_c[1] ? cmd1_c : cmd0_c;
    assign req_c  = {avs_s1_read | avs_s1_write, avs_s0_read | avs_s0_write};

    assign avs_s0_readdata = rdata_q;
    assign avs_s1_readdata = rdata_q;

    rr_arb2 u_arb (
        .req        (req_c),
        .last_grant (last_grant),
        .gnt_c      (gnt_c)
    );

    // Sequencer: grant, one downstream command, optional settle, one-cycle response.
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state              <= ST_IDLE;
            timer              <= '0;
            settle_cnt         <= '0;
            gnt_port           <= 1'b0;
            last_grant         <= 1'b1;
            rdata_q            <= '0;
            avm_m0_address     <= '0;
            avm_m0_writedata   <= '0;
            avm_m0_byteenable  <= '0;
            avm_m0_read        <= 1'b0;
            avm_m0_write       <= 1'b0;
            avs_s0_waitrequest <= 1'b1;
            avs_s1_waitrequest <= 1'b1;
            coe_err_sticky     <= 1'b0;
            coe_err_cnt        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|gnt_c) begin
                        gnt_port          <= gnt_c[1];
                        avm_m0_address    <= sel_c.addr;
                        avm_m0_writedata  <= sel_c.wdata;
                        avm_m0_byteenable <= sel_c.be;
                        avm_m0_read       <= sel_c.rd;
                        avm_m0_write      <= sel_c.wr;
                        timer             <= '0;
                        state             <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!avm_m0_waitrequest) begin
                        avm_m0_read  <= 1'b0;
                        avm_m0_write <= 1'b0;
                        if (avm_m0_read && (RD_SETTLE != 0)) begin
                            settle_cnt <= '0;
                            state      <= ST_SETTLE;
                        end else begin
                            if (avm_m0_read) rdata_q <= avm_m0_readdata;
                            {avs_s1_waitrequest, avs_s0_waitrequest} <= gnt_port ? 2'b01 : 2'b10;
                            state <= ST_RESP;
                        end
                    end else if (timer == TIMER_LAST) begin
                        avm_m0_read    <= 1'b0;
                        avm_m0_write   <= 1'b0;
                        coe_err_sticky <= 1'b1;
                        if (coe_err_cnt != 8'hFF) coe_err_cnt <= coe_err_cnt + 8'd1;
                        rdata_q <= ERR_RDATA;
                        {avs_s1_waitrequest, avs_s0_waitrequest} <= gnt_port ? 2'b01 : 2'b10;
                        state <= ST_RESP;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        rdata_q <= avm_m0_readdata;
                        {avs_s1_waitrequest, avs_s0_waitrequest} <= gnt_port ? 2'b01 : 2'b10;
                        state <= ST_RESP;
                    end else begin
                        settle_cnt <= settle_cnt + 2'd1;
                    end
                end
                ST_RESP: begin
                    avs_s0_waitrequest <= 1'b1;
                    avs_s1_waitrequest <= 1'b1;
                    last_grant         <= gnt_port;
                    state              <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avmm_arb2_rw16.sv
// Bench for avmm_arb2_rw16: test register slave (addr 0 set bytes, addr 1 clear
// bytes, read returns value + address) with a switchable stuck-waitrequest stub.
module tb_avmm_arb2_rw16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic [15:0] s0_wdata, s0_rdata, s1_wdata, s1_rdata;
    logic [5:0]  s0_addr, s1_addr;
    logic [1:0]  s0_be, s1_be;
    logic        s0_write, s0_read, s0_wait, s1_write, s1_read, s1_wait;
    logic [15:0] m0_wdata, m0_rdata;
    logic [5:0]  m0_addr;
    logic [1:0]  m0_be;
    logic        m0_write, m0_read, m0_wait;
    logic        err_sticky;
    logic [7:0]  err_cnt;

    logic        stuck = 1'b0;
    logic [15:0] slave_reg = 16'h0000;
    logic [15:0] slave_rq  = 16'h0000;

    int checks = 0;
    int errors = 0;
    int m0_acc = 0;

    typedef struct {
        int          port;
        bit          is_rd;
        logic [15:0] rdata;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int          port;
        bit          rd;
        bit          wr;
        logic [5:0]  addr;
        logic [15:0] wd;
        logic [1:0]  be;
        logic [15:0] exp_rd;
        int          lat;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    avmm_arb2_rw16 #(.TIMEOUT(64), .RD_SETTLE(1), .ERR_RDATA(16'hDEAD)) dut (
        .csi_MCLK_clk       (clk),
        .rsi_MRST_reset_n   (rst_n),
        .avs_s0_writedata   (s0_wdata),
        .avs_s0_readdata    (s0_rdata),
        .avs_s0_address     (s0_addr),
        .avs_s0_byteenable  (s0_be),
        .avs_s0_write       (s0_write),
        .avs_s0_read        (s0_read),
        .avs_s0_waitrequest (s0_wait),
        .avs_s1_writedata   (s1_wdata),
        .avs_s1_readdata    (s1_rdata),
        .avs_s1_address     (s1_addr),
        .avs_s1_byteenable  (s1_be),
        .avs_s1_write       (s1_write),
        .avs_s1_read        (s1_read),
        .avs_s1_waitrequest (s1_wait),
        .avm_m0_writedata   (m0_wdata),
        .avm_m0_readdata    (m0_rdata),
        .avm_m0_address     (m0_addr),
        .avm_m0_byteenable  (m0_be),
        .avm_m0_write       (m0_write),
        .avm_m0_read        (m0_read),
        .avm_m0_waitrequest (m0_wait),
        .coe_err_sticky     (err_sticky),
        .coe_err_cnt        (err_cnt)
    );

    // Downstream test register slave with registered readdata.
    assign m0_wait  = stuck;
    assign m0_rdata = slave_rq;

    always @(posedge clk) begin
        if (m0_write && !m0_wait) begin
            if (m0_addr == 6'd0) begin
                if (m0_be[0]) slave_reg[7:0]  <= m0_wdata[7:0];
                if (m0_be[1]) slave_reg[15:8] <= m0_wdata[15:8];
            end else if (m0_addr == 6'd1) begin
                if (m0_be[0]) slave_reg[7:0]  <= slave_reg[7:0]  & ~m0_wdata[7:0];
                if (m0_be[1]) slave_reg[15:8] <= slave_reg[15:8] & ~m0_wdata[15:8];
            end
        end
        if (m0_read && !m0_wait) slave_rq <= slave_reg + 16'(m0_addr);
    end

    task automatic check_resp(input int p, input logic [15:0] rd);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_resp port=%0d (no transfer outstanding)", p);
        end else begin
            e = sbq.pop_front();
            if (e.port != p) begin
                errors++;
                $display("FAIL resp_port got=%0d want=%0d", p, e.port);
            end
            if (e.is_rd) begin
                checks++;
                if (rd !== e.rdata) begin
                    errors++;
                    $display("FAIL resp_rdata port=%0d got=%h want=%h", p, rd, e.rdata);
                end
            end
        end
    endtask

    // Upstream response monitor and downstream command checker.
    always @(negedge clk) begin
        if (rst_n) begin
            if (m0_read && m0_write) begin
                errors++;
                $display("FAIL m0_overlap read=%b write=%b want one-hot", m0_read, m0_write);
            end
            if ((m0_read || m0_write) && !m0_wait) m0_acc++;
            if ((s0_read || s0_write) && !s0_wait) check_resp(0, s0_rdata);
            if ((s1_read || s1_write) && !s1_wait) check_resp(1, s1_rdata);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic set_port(input int p, input bit rd, input bit wr, input logic [5:0] a,
                            input logic [15:0] wd, input logic [1:0] be);
        if (p == 0) begin
            s0_read = rd; s0_write = wr; s0_addr = a; s0_wdata = wd; s0_be = be;
        end else begin
            s1_read = rd; s1_write = wr; s1_addr = a; s1_wdata = wd; s1_be = be;
        end
    endtask

    // One upstream transfer; called and returns just after a rising edge.
    task automatic xfer(input int id, input int p, input bit rd, input bit wr, input logic [5:0] a,
                        input logic [15:0] wd, input logic [1:0] be, input logic [15:0] exp_rd,
                        input int exp_lat, input int exp_m0);
        int lat;
        int acc0;
        exp_t e;
        e.port = p; e.is_rd = rd; e.rdata = exp_rd;
        sbq.push_back(e);
        acc0 = m0_acc;
        set_port(p, rd, wr, a, wd, be);
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if ((p == 0 ? s0_wait : s1_wait) == 1'b0) begin
                lat = i;
                break;
            end
        end
        @(posedge clk);
        #1;
        set_port(p, 1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL xfer%0d_latency got=%0d want=%0d", id, lat, exp_lat);
        end
        checks++;
        if ((m0_acc - acc0) != exp_m0) begin
            errors++;
            $display("FAIL xfer%0d_m0_cmds got=%0d want=%0d", id, m0_acc - acc0, exp_m0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int n1;
        exp_t e;

        vecs[0]  = '{0, 1'b0, 1'b1, 6'd0, 16'h1234, 2'b11, 16'h0000, 2};
        vecs[1]  = '{1, 1'b1, 1'b0, 6'd3, 16'h0000, 2'b11, 16'h1237, 3};
        vecs[2]  = '{0, 1'b0, 1'b1, 6'd1, 16'h00FF, 2'b01, 16'h0000, 2};
        vecs[3]  = '{0, 1'b1, 1'b0, 6'd0, 16'h0000, 2'b11, 16'h1200, 3};
        vecs[4]  = '{1, 1'b0, 1'b1, 6'd0, 16'hABCD, 2'b10, 16'h0000, 2};
        vecs[5]  = '{1, 1'b1, 1'b0, 6'd5, 16'h0000, 2'b11, 16'hAB05, 3};
        vecs[6]  = '{0, 1'b0, 1'b1, 6'd0, 16'h0066, 2'b01, 16'h0000, 2};
        vecs[7]  = '{0, 1'b1, 1'b0, 6'd2, 16'h0000, 2'b11, 16'hAB68, 3};
        vecs[8]  = '{1, 1'b0, 1'b1, 6'd1, 16'hFFFF, 2'b10, 16'h0000, 2};
        vecs[9]  = '{0, 1'b1, 1'b1, 6'd0, 16'h0000, 2'b11, 16'h0066, 3};
        vecs[10] = '{1, 1'b1, 1'b0, 6'd0, 16'h0000, 2'b11, 16'h0066, 3};

        set_port(0, 1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
        set_port(1, 1'b0, 1'b0, 6'd0, 16'h0, 2'b00);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_m0_read",  32'(m0_read),    32'd0);
        chk("rst_m0_write", 32'(m0_write),   32'd0);
        chk("rst_m0_addr",  32'(m0_addr),    32'd0);
        chk("rst_m0_wdata", 32'(m0_wdata),   32'd0);
        chk("rst_m0_be",    32'(m0_be),      32'd0);
        chk("rst_s0_wait",  32'(s0_wait),    32'd1);
        chk("rst_s1_wait",  32'(s1_wait),    32'd1);
        chk("rst_s0_rdata", 32'(s0_rdata),   32'd0);
        chk("rst_s1_rdata", 32'(s1_rdata),   32'd0);
        chk("rst_sticky",   32'(err_sticky), 32'd0);
        chk("rst_cnt",      32'(err_cnt),    32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++)
            xfer(i, vecs[i].port, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                 vecs[i].be, vecs[i].exp_rd, vecs[i].lat, 1);

        // Stuck slave: abort after 64 command cycles.
        stuck = 1'b1;
        xfer(100, 1, 1'b1, 1'b0, 6'd7, 16'h0, 2'b11, 16'hDEAD, 65, 0);
        chk("abort1_sticky", 32'(err_sticky), 32'd1);
        chk("abort1_cnt",    32'(err_cnt),    32'd1);
        for (int i = 0; i < 255; i++)
            xfer(200 + i, i % 2, 1'b0, 1'b1, 6'd0, 16'hFFFF, 2'b11, 16'h0000, 65, 0);
        chk("abort256_cnt",    32'(err_cnt),    32'd255);
        chk("abort256_sticky", 32'(err_sticky), 32'd1);
        stuck = 1'b0;
        xfer(500, 0, 1'b1, 1'b0, 6'd4, 16'h0, 2'b11, 16'h006A, 3, 1);
        chk("after_abort_cnt", 32'(err_cnt), 32'd255);

        // Reset while a read is stuck in the downstream command phase.
        stuck = 1'b1;
        set_port(0, 1'b1, 1'b0, 6'd0, 16'h0, 2'b11);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("mid_m0_read_before_rst", 32'(m0_read), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m0_read",  32'(m0_read),    32'd0);
        chk("mid_rst_m0_write", 32'(m0_write),   32'd0);
        chk("mid_rst_s0_wait",  32'(s0_wait),    32'd1);
        chk("mid_rst_s1_wait",  32'(s1_wait),    32'd1);
        chk("mid_rst_sticky",   32'(err_sticky), 32'd0);
        chk("mid_rst_cnt",      32'(err_cnt),    32'd0);
        set_port(0, 1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
        stuck = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Contention: both ports hold reads for two transfers each.
        e.is_rd = 1'b1;
        e.port = 0; e.rdata = 16'h0066; sbq.push_back(e);
        e.port = 1; e.rdata = 16'h0067; sbq.push_back(e);
        e.port = 0; e.rdata = 16'h0066; sbq.push_back(e);
        e.port = 1; e.rdata = 16'h0067; sbq.push_back(e);
        set_port(0, 1'b1, 1'b0, 6'd0, 16'h0, 2'b11);
        set_port(1, 1'b1, 1'b0, 6'd1, 16'h0, 2'b11);
        n0 = 0;
        n1 = 0;
        for (int c = 0; c < 100 && (n0 < 2 || n1 < 2); c++) begin
            @(negedge clk);
            if (!s0_wait) n0++;
            if (!s1_wait) n1++;
            @(posedge clk);
            #1;
            if (n0 >= 2) set_port(0, 1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
            if (n1 >= 2) set_port(1, 1'b0, 1'b0, 6'd0, 16'h0, 2'b00);
        end
        chk("contend_s0_count", 32'(n0), 32'd2);
        chk("contend_s1_count", 32'(n1), 32'd2);

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
